// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/MEM unified-memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_MEM
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use <= so all flops update together at the edge.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign out = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one single-port memory with wait states.
// Stall statistics counters are built only when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              pipe_stall,
    output logic [15:0]       stat_if_stall,
    output logic [15:0]       stat_mem_stall
);

    arb_state_t        state_q, state_d;
    grant_t            grant_q, grant_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_wins;

    // MEM has priority unless IF has already waited out STARVE_LIMIT MEM grants.
    assign mem_wins = mem_req && !(if_req && (starve_cnt_q == 4'(STARVE_LIMIT)));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        we_d         = we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    if (mem_wins) begin
                        grant_d      = GNT_MEM;
                        ram_addr_d   = mem_addr;
                        ram_wdata_d  = mem_wdata;
                        we_d         = mem_we;
                        starve_cnt_d = if_req ? starve_cnt_q + 4'd1 : 4'd0;
                    end else begin
                        grant_d      = GNT_IF;
                        ram_addr_d   = if_addr;
                        we_d         = 1'b0;
                        starve_cnt_d = 4'd0;
                    end
                    wait_cnt_d = 4'(WAIT_STATES);
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt_q == 4'd0) begin
                    if (grant_q == GNT_IF) begin
                        if_rdata_d = ram_rdata;
                    end else if ((grant_q == GNT_MEM) && !we_q) begin
                        mem_rdata_d = ram_rdata;
                    end
                    state_d = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_NONE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    // Write strobe only in the final access cycle, so a store commits exactly once.
    assign ram_en     = (state_q == ST_ACCESS);
    assign ram_we     = ram_en && (wait_cnt_q == 4'd0) && (grant_q == GNT_MEM) && we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ack     = (state_q == ST_ACK) && (grant_q == GNT_IF);
    assign mem_ack    = (state_q == ST_ACK) && (grant_q == GNT_MEM);
    assign pipe_stall = (if_req && !if_ack) || (mem_req && !mem_ack);

`ifdef MEM_ARB_STATS_EN
    sat_counter #(.WIDTH(16)) u_if_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (if_req && !if_ack),
        .out (stat_if_stall)
    );

    sat_counter #(.WIDTH(16)) u_mem_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (mem_req && !mem_ack),
        .out (stat_mem_stall)
    );
`else
    assign stat_if_stall  = 16'h0000;
    assign stat_mem_stall = 16'h0000;
`endif

    // Requesters must keep address/data stable until their ack.
    a_if_stable: assert property (@(posedge clk) disable iff (rst)
        (if_req && !if_ack) |=> (!if_req || $stable(if_addr)));
    a_mem_stable: assert property (@(posedge clk) disable iff (rst)
        (mem_req && !mem_ack) |=> (!mem_req || ($stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata))));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (WAIT_STATES=1, STARVE_LIMIT=4).
// Stat-counter checks follow MEM_ARB_STATS_EN.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [11:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        ram_en;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        pipe_stall;
    logic [15:0] stat_if_stall;
    logic [15:0] stat_mem_stall;

    logic [15:0] mem_model [0:4095];
    int          we_pulses = 0;
    logic [11:0] we_addr   = '0;
    int          errors    = 0;
    int          checks    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (12),
        .DATA_W       (16),
        .WAIT_STATES  (1),
        .STARVE_LIMIT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_ack         (if_ack),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .pipe_stall     (pipe_stall),
        .stat_if_stall  (stat_if_stall),
        .stat_mem_stall (stat_mem_stall)
    );

    assign ram_rdata = mem_model[ram_addr];

    // Memory model: preload, then commit writes seen at each rising edge.
    initial begin
        for (int i = 0; i < 4096; i++) mem_model[i] = 16'h0000;
        mem_model[12'h010] = 16'hA5A5;
        forever begin
            @(posedge clk);
            if (ram_en && ram_we) begin
                mem_model[ram_addr] = ram_wdata;
                we_pulses++;
                we_addr = ram_addr;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, input bit is_if, input int budget, output int lat);
        lat = 0;
        #1;
        while (!(is_if ? if_ack : mem_ack) && lat < budget) begin
            step();
            lat++;
        end
        check({tag, "_ack"}, is_if ? if_ack : mem_ack, 1);
    endtask

    int lat;
    int k;
    int n;
    int p0;
    logic [5:0] seq;
    bit drop_if;
    bit ack_seen;

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        repeat (3) step();
        #1;
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_mem_ack", mem_ack, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_stall", pipe_stall, 0);
        rst = 1'b0;
        step();

        // Single fetch: ack two cycles plus one wait state after the request.
        step();
        if_req = 1'b1; if_addr = 12'h010;
        #1 check("t1_stall_c0", pipe_stall, 1);
        step(); #1;
        check("t1_stall_c1", pipe_stall, 1);
        check("t1_ram_en", ram_en, 1);
        check("t1_ram_addr", ram_addr, 12'h010);
        check("t1_noack_c1", if_ack, 0);
        step(); #1;
        check("t1_stall_c2", pipe_stall, 1);
        check("t1_noack_c2", if_ack, 0);
        step(); #1;
        check("t1_if_ack", if_ack, 1);
        check("t1_if_rdata", if_rdata, 16'hA5A5);
        check("t1_stall_ack", pipe_stall, 0);
        check("t1_ram_en_ack", ram_en, 0);
        step();
        if_req = 1'b0;
        #1 check("t1_ack_pulse", if_ack, 0);
`ifdef MEM_ARB_STATS_EN
        check("t1_stat_if", stat_if_stall, 3);
`else
        check("t1_stat_if_tied", stat_if_stall, 0);
        check("t1_stat_mem_tied", stat_mem_stall, 0);
`endif

        // Store then load-back.
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'h020; mem_wdata = 16'h1234;
        p0 = we_pulses;
        wait_ack("t2_st", 1'b0, 10, lat);
        check("t2_st_lat", lat, 3);
        check("t2_we_pulses", we_pulses - p0, 1);
        check("t2_we_addr", we_addr, 12'h020);
        check("t2_mem_data", mem_model[12'h020], 16'h1234);
        step();
        mem_req = 1'b0; mem_we = 1'b0;
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h020;
        wait_ack("t2_ld", 1'b0, 10, lat);
        check("t2_ld_lat", lat, 3);
        check("t2_ld_data", mem_rdata, 16'h1234);
        step();
        mem_req = 1'b0;

        // Simultaneous requests: MEM first, IF one full access later.
        step();
        if_req = 1'b1; if_addr = 12'h010;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h020;
        wait_ack("t3_mem", 1'b0, 10, lat);
        check("t3_mem_lat", lat, 3);
        check("t3_if_quiet", if_ack, 0);
        check("t3_stall", pipe_stall, 1);
        for (k = 1; k <= 12; k++) begin
            step();
            if (k == 1) mem_req = 1'b0;
            #1;
            if (if_ack) break;
        end
        check("t3_if_gap", k, 4);
        check("t3_if_rdata", if_rdata, 16'hA5A5);
        step();
        if_req = 1'b0;

        // Starvation guard: four MEM grants, then IF, then MEM again.
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h020;
        if_req = 1'b1; if_addr = 12'h010;
        seq = '0; n = 0; drop_if = 1'b0;
        for (int c = 0; c < 80 && n < 6; c++) begin
            step();
            if (drop_if) begin
                if_req = 1'b0;
                drop_if = 1'b0;
            end
            #1;
            if (mem_ack) begin
                seq = {seq[4:0], 1'b1};
                n++;
            end
            if (if_ack) begin
                seq = {seq[4:0], 1'b0};
                n++;
                drop_if = 1'b1;
            end
        end
        check("t4_grants", n, 6);
        check("t4_order", seq, 6'b111101);
        step();
        mem_req = 1'b0;

        // Reset during the first cycle of a store's access.
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'h030; mem_wdata = 16'hBEEF;
        p0 = we_pulses;
        step(); #1;
        check("t5_in_access", ram_en, 1);
        check("t5_no_we_yet", ram_we, 0);
        rst = 1'b1;
        step();
        mem_req = 1'b0; mem_we = 1'b0;
        #1;
        check("t5_ram_en", ram_en, 0);
        check("t5_ram_we", ram_we, 0);
        check("t5_mem_ack", mem_ack, 0);
        check("t5_ram_addr", ram_addr, 0);
        check("t5_ram_wdata", ram_wdata, 0);
        check("t5_if_rdata", if_rdata, 0);
        check("t5_mem_rdata", mem_rdata, 0);
        check("t5_stat_if", stat_if_stall, 0);
        rst = 1'b0;
        ack_seen = 1'b0;
        repeat (6) begin
            step();
            ack_seen = ack_seen | if_ack | mem_ack;
        end
        check("t5_no_ack", ack_seen, 0);
        check("t5_no_write", we_pulses - p0, 0);
        check("t5_mem_untouched", mem_model[12'h030], 16'h0000);

`ifdef MEM_ARB_STATS_EN
        // Both requesters held: IF stalls 19 of every 20 cycles, enough to saturate.
        step();
        if_req = 1'b1; if_addr = 12'h010;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h020;
        repeat (70000) step();
        #1 check("t6_if_sat", stat_if_stall, 16'hFFFF);
        rst = 1'b1;
        step();
        if_req = 1'b0; mem_req = 1'b0;
        #1 check("t6_clr", stat_if_stall, 0);
        rst = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
